r5_input_gather: RTL and testbench



---
 rtl/r5_pkg.sv | 15 +
 rtl/r5_gather_bank.sv | 60 ++++++
 rtl/r5_input_gather.sv | 105 ++++++++++
 tb/tb_r5_input_gather.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/r5_pkg.sv
// Shared constants and types for the radix-5 input gather stage.
package r5_pkg;

    localparam int unsigned FW    = 32;
    localparam int unsigned RADIX = 5;
    localparam int unsigned SLOTW = 3;

    typedef logic [SLOTW-1:0] slot_t;

    typedef struct packed {
        logic [FW-1:0] re;
        logic [FW-1:0] img;
    } cplx_t;

endpackage

// File: rtl/r5_gather_bank.sv
// One frame buffer: RADIX complex slots, per-slot write, full flag, parallel read.
module r5_gather_bank
    import r5_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  slot_t               wr_slot_i,
    input  cplx_t               wr_data_i,
    input  logic                set_full_i,
    input  logic                clr_full_i,
    output logic                full_o,
    output logic [RADIX*FW-1:0] rd_re_o,
    output logic [RADIX*FW-1:0] rd_img_o
);

    cplx_t data_q [RADIX];
    cplx_t data_d [RADIX];
    logic  full_q;
    logic  full_d;

    always_comb begin
        data_d = data_q;
        for (int k = 0; k < RADIX; k++) begin
            if (wr_en_i && (wr_slot_i == slot_t'(k))) begin
                data_d[k] = wr_data_i;
            end
        end
        full_d = full_q;
        if (set_full_i) begin
            full_d = 1'b1;
        end else if (clr_full_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RADIX; k++) begin
                data_q[k] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    always_comb begin
        rd_re_o  = '0;
        rd_img_o = '0;
        for (int k = 0; k < RADIX; k++) begin
            rd_re_o[FW*k +: FW]  = data_q[k].re;
            rd_img_o[FW*k +: FW] = data_q[k].img;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/r5_input_gather.sv
// Serial-to-parallel ping-pong gather: 5 complex samples in, one parallel frame out.
module r5_input_gather
    import r5_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FW-1:0]       in_re,
    input  logic [FW-1:0]       in_img,
    input  logic                in_sop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RADIX*FW-1:0] out_re,
    output logic [RADIX*FW-1:0] out_img,
    output logic                sop_err
);

    slot_t idx_q, idx_d;
    logic  wr_bank_q, wr_bank_d;
    logic  rd_bank_q, rd_bank_d;
    logic  sop_err_q, sop_err_d;

    logic                accept, fire, complete;
    slot_t               wr_slot;
    cplx_t               wr_data;
    logic [1:0]          full, wr_en, set_full, clr_full;
    logic [RADIX*FW-1:0] rd_re  [2];
    logic [RADIX*FW-1:0] rd_img [2];

    assign in_ready  = !full[wr_bank_q];
    assign out_valid = full[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    // A realigning sample always lands in slot 0, so it can never complete a frame.
    assign wr_slot   = in_sop ? slot_t'(0) : idx_q;
    assign complete  = accept && !in_sop && (idx_q == slot_t'(RADIX - 1));
    assign wr_data   = '{re: in_re, img: in_img};

    always_comb begin
        idx_d     = idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        sop_err_d = sop_err_q;
        if (accept) begin
            if (in_sop) begin
                idx_d = slot_t'(1);
                if (idx_q != slot_t'(0)) begin
                    sop_err_d = 1'b1;
                end
            end else if (complete) begin
                idx_d     = slot_t'(0);
                wr_bank_d = !wr_bank_q;
            end else begin
                idx_d = idx_q + slot_t'(1);
            end
        end
        if (fire) begin
            rd_bank_d = !rd_bank_q;
        end
    end

    always_comb begin
        wr_en    = '0;
        set_full = '0;
        clr_full = '0;
        wr_en[wr_bank_q]    = accept;
        set_full[wr_bank_q] = complete;
        clr_full[rd_bank_q] = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            sop_err_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            sop_err_q <= sop_err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        r5_gather_bank u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (wr_en[b]),
            .wr_slot_i  (wr_slot),
            .wr_data_i  (wr_data),
            .set_full_i (set_full[b]),
            .clr_full_i (clr_full[b]),
            .full_o     (full[b]),
            .rd_re_o    (rd_re[b]),
            .rd_img_o   (rd_img[b])
        );
    end

    assign out_re  = rd_re[rd_bank_q];
    assign out_img = rd_img[rd_bank_q];
    assign sop_err = sop_err_q;

endmodule

// File: tb/tb_r5_input_gather.sv
// Bench for r5_input_gather: directed scenarios plus random backpressure against a frame-queue model.
module tb_r5_input_gather;
    import r5_pkg::*;

    localparam int unsigned VW = RADIX * FW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_re = '0;
    logic [FW-1:0] in_img = '0;
    logic          in_sop = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_re;
    logic [VW-1:0] out_img;
    logic          sop_err;

    always #5 clk = ~clk;

    r5_input_gather dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_img    (in_img),
        .in_sop    (in_sop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_img   (out_img),
        .sop_err   (sop_err)
    );

    // Model: samples of the frame being built, completed frames awaiting the consumer.
    logic [FW-1:0] part_re  [$];
    logic [FW-1:0] part_img [$];
    logic [VW-1:0] exp_re   [$];
    logic [VW-1:0] exp_img  [$];
    logic          sop_err_m = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int nfire   = 0;
    bit acc_last;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        part_re.delete();
        part_img.delete();
        exp_re.delete();
        exp_img.delete();
        sop_err_m = 1'b0;
    endtask

    // Check outputs against the model, then advance one clock and update the model.
    task automatic tick();
        bit rdy_e, val_e, acc, fire;
        logic [VW-1:0] fr, fi;
        rdy_e = (exp_re.size() < 2);
        val_e = (exp_re.size() > 0);
        chk("in_ready", VW'(in_ready), VW'(rdy_e));
        chk("out_valid", VW'(out_valid), VW'(val_e));
        chk("sop_err", VW'(sop_err), VW'(sop_err_m));
        if (val_e) begin
            chk("out_re", out_re, exp_re[0]);
            chk("out_img", out_img, exp_img[0]);
        end
        acc  = in_valid && rdy_e;
        fire = val_e && out_ready;
        @(posedge clk);
        if (fire) begin
            void'(exp_re.pop_front());
            void'(exp_img.pop_front());
            nfire++;
        end
        if (acc) begin
            if (in_sop && part_re.size() != 0) begin
                part_re.delete();
                part_img.delete();
                sop_err_m = 1'b1;
            end
            part_re.push_back(in_re);
            part_img.push_back(in_img);
            if (part_re.size() == RADIX) begin
                fr = '0;
                fi = '0;
                for (int k = 0; k < RADIX; k++) begin
                    fr[FW*k +: FW] = part_re[k];
                    fi[FW*k +: FW] = part_img[k];
                end
                exp_re.push_back(fr);
                exp_img.push_back(fi);
                part_re.delete();
                part_img.delete();
            end
        end
        acc_last = acc;
        #1;
    endtask

    // Present one sample and hold it until accepted, bounded.
    task automatic send(input logic [FW-1:0] re, input logic [FW-1:0] im, input logic sop);
        int n;
        in_valid = 1'b1;
        in_re    = re;
        in_img   = im;
        in_sop   = sop;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_last && n < 50);
        if (!acc_last) begin
            chk("send_timeout", VW'(1), VW'(0));
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [FW-1:0] one_to_five [5];

    initial begin
        int cnt, accepted, guard;
        one_to_five[0] = 32'h3F80_0000;
        one_to_five[1] = 32'h4000_0000;
        one_to_five[2] = 32'h4040_0000;
        one_to_five[3] = 32'h4080_0000;
        one_to_five[4] = 32'h40A0_0000;

        // Reset state
        #12;
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_in_ready", VW'(in_ready), VW'(1));
        chk("rst_out_re", out_re, '0);
        chk("rst_sop_err", VW'(sop_err), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First frame 1.0..5.0
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(one_to_five[i], '0, (i == 0));
        chk("t1_valid", VW'(out_valid), VW'(1));
        chk("t1_slot0", VW'(out_re[31:0]), VW'(32'h3F80_0000));
        chk("t1_slot4", VW'(out_re[159:128]), VW'(32'h40A0_0000));
        chk("t1_img", out_img, '0);
        chk("t1_sop_err", VW'(sop_err), VW'(0));
        idle(2);

        // Continuous stream of 20 with consumer always ready
        cnt = nfire;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_re  = $urandom;
            in_img = $urandom;
            in_sop = (i % 5 == 0);
            tick();
            chk("t2_accept", VW'(acc_last), VW'(1));
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        tick();
        chk("t2_frames", VW'(nfire - cnt), VW'(4));
        idle(2);

        // Consumer stalled: two frames buffered, input blocks
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(32'h1000_0000 + i, 32'h2000_0000 + i, 1'b0);
        chk("t3_in_ready_low", VW'(in_ready), VW'(0));
        in_valid = 1'b1;
        in_re    = 32'h7FC0_0001;
        in_img   = 32'hFF80_0000;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_stalled", VW'(acc_last), VW'(0));
        out_ready = 1'b1;
        send(32'h7FC0_0001, 32'hFF80_0000, 1'b0);
        send(32'h0000_0001, 32'h8000_0000, 1'b0);
        chk("t3_in_ready_back", VW'(in_ready), VW'(1));
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0);
        idle(3);

        // Realignment mid-frame
        for (int i = 0; i < 3; i++) send(32'hDEAD_0000 + i, 32'hBEEF_0000 + i, (i == 0));
        send(32'hCAFE_0000, 32'hF00D_0000, 1'b1);
        for (int i = 1; i < 5; i++) send(32'hCAFE_0000 + i, 32'hF00D_0000 + i, 1'b0);
        chk("t4_sop_err", VW'(sop_err), VW'(1));
        chk("t4_slot0", VW'(out_re[31:0]), VW'(32'hCAFE_0000));
        idle(4);
        chk("t4_sticky", VW'(sop_err), VW'(1));

        // Reset with one full bank and a partial frame
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send($urandom, $urandom, 1'b0);
        chk("t5_pre_valid", VW'(out_valid), VW'(1));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_valid", VW'(out_valid), VW'(0));
        chk("t5_rst_re", out_re, '0);
        chk("t5_rst_img", out_img, '0);
        chk("t5_rst_sop_err", VW'(sop_err), VW'(0));
        chk("t5_rst_in_ready", VW'(in_ready), VW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'b0);
        chk("t5_no_frame", VW'(out_valid), VW'(0));
        send($urandom, $urandom, 1'b0);
        chk("t5_frame", VW'(out_valid), VW'(1));
        idle(2);

        // Random traffic with backpressure
        accepted = 0;
        guard    = 0;
        while (accepted < 1000 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sop    = ($urandom_range(0, 31) == 0);
            in_re     = $urandom;
            in_img    = $urandom;
            tick();
            if (acc_last) accepted++;
            guard++;
        end
        if (accepted < 1000) chk("t6_timeout", VW'(accepted), VW'(1000));
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("t6_drained", VW'(exp_re.size()), VW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
